jtag_idcode_reader: RTL and testbench

Host-side JTAG initiator that reads the 32-bit IDCODE from a target TAP.
- Generates TCK, TMS and TDI from the system clock and walks the target TAP: Test-Logic-Reset → Shift-DR → Run-Test/Idle.
- Captures the 32 bits the target's device identification register shifts out on TDO.
- Sits at the top level next to the TAP-side logic; used on-chip for loopback self-test and as the bench's reference host.

---
 rtl/jtag_idcode_reader.sv | 140 ++++++++++++++
 tb/tb_jtag_idcode_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_idcode_reader.sv
// jtag_idcode_reader: host-side JTAG initiator that reads the 32-bit IDCODE
// of a target TAP. It walks Test-Logic-Reset -> Shift-DR -> Run-Test/Idle,
// shifts 32 TDO bits (LSB first) and reports them on idcode.
// Optional macro IDCODE_CHECK_EN: when defined, id_err flags a captured code
// with bit 0 clear or an all-ones code (stuck-high TDO / no target).
`timescale 1ns/1ps

module jtag_idcode_reader #(
  parameter int TCK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] idcode,
  output logic        id_err,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [2:0] {
    S_IDLE, S_TLR, S_NAV, S_SHIFT, S_EXIT, S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [7:0]  div_cnt, div_n;
  logic        tck_n, tms_n;
  logic [5:0]  last_cnt;
  logic        term, rise, fall, load;
  logic [31:0] shreg;

  assign busy = (state == S_TLR) || (state == S_NAV) ||
                (state == S_SHIFT) || (state == S_EXIT);
  assign done = (state == S_DONE);
  assign tdi  = 1'b1;

  // Next-state, TCK phase and TMS decode; TMS only moves with the state,
  // which in turn only advances on TCK falling edges (or on start).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_cnt;
    tck_n   = tck;
    tms_n   = 1'b1;
    load    = 1'b0;

    term = (div_cnt == DIV_LAST);
    rise = term && !tck;
    fall = term && tck;

    case (state)
      S_TLR:   last_cnt = 6'd4;
      S_NAV:   last_cnt = 6'd3;
      S_SHIFT: last_cnt = 6'd31;
      default: last_cnt = 6'd1;
    endcase

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_TLR;
          cnt_n   = 6'd0;
          div_n   = 8'd0;
          tck_n   = 1'b0;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        div_n = term ? 8'd0 : div_cnt + 8'd1;
        if (term) tck_n = ~tck;
        if (fall) begin
          if (cnt == last_cnt) begin
            cnt_n = 6'd0;
            case (state)
              S_TLR:   state_n = S_NAV;
              S_NAV:   state_n = S_SHIFT;
              S_SHIFT: state_n = S_EXIT;
              default: begin
                state_n = S_DONE;
                load    = 1'b1;
              end
            endcase
          end else begin
            cnt_n = cnt + 6'd1;
          end
        end
      end
    endcase

    // TMS for the TCK cycle that starts after this edge.
    case (state_n)
      S_NAV:   tms_n = (cnt_n == 6'd1);
      S_SHIFT: tms_n = (cnt_n == 6'd31);
      S_EXIT:  tms_n = (cnt_n == 6'd0);
      default: tms_n = 1'b1;
    endcase
  end

  // Control registers; rst clears every output, so a partial read never
  // reaches idcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      div_cnt <= 8'd0;
      tck     <= 1'b0;
      tms     <= 1'b1;
      idcode  <= 32'h0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_cnt <= div_n;
      tck     <= tck_n;
      tms     <= tms_n;
      if (load) idcode <= shreg;
    end
  end

  // TDO capture on TCK rising edges in Shift-DR; LSB arrives first.
  always_ff @(posedge clk) begin
    if ((state == S_SHIFT) && rise) shreg <= {tdo, shreg[31:1]};
  end

`ifdef IDCODE_CHECK_EN
  // Integrity flag: IEEE 1149.1 codes end in 1; all ones means no target.
  always_ff @(posedge clk) begin
    if (rst)       id_err <= 1'b0;
    else if (load) id_err <= (shreg[0] == 1'b0) || (&shreg);
  end
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Testbench for jtag_idcode_reader: three instances (TCK_DIV 2, 1, 5), each
// driving a behavioural 16-state TAP that holds a settable IDCODE.
`timescale 1ns/1ps

module tb_jtag_idcode_reader;

  localparam int TLR = 0,  RTI = 1,  SEL_DR = 2,  CAP_DR = 3,  SH_DR = 4,
                 EX1_DR = 5, PAU_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9,
                 CAP_IR = 10, SH_IR = 11, EX1_IR = 12, PAU_IR = 13,
                 EX2_IR = 14, UPD_IR = 15;

  logic        clk;
  logic        rst;
  logic        start  [3];
  logic        busy   [3];
  logic        done   [3];
  logic [31:0] idcode [3];
  logic        id_err [3];
  logic        tck    [3];
  logic        tms    [3];
  logic        tdi    [3];
  logic        tdo    [3];
  logic [31:0] idval  [3];
  logic        stuck  [3];

  int n_chk = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 5;
  endfunction

  function automatic logic exp_err(input logic [31:0] v);
`ifdef IDCODE_CHECK_EN
    return (v[0] == 1'b0) || (v == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : tap
    localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    int          st;
    logic [31:0] dr;
    logic        tdo_m;
    int          rise_cnt;
    bit          tms_hist [4096];
    int          st_hist  [4096];

    initial begin
      st       = $urandom_range(0, 15);
      dr       = 32'h0;
      tdo_m    = 1'b1;
      rise_cnt = 0;
    end

    always @(posedge tck[g]) begin
      if (st == CAP_DR)     dr <= idval[g];
      else if (st == SH_DR) dr <= {tdi[g], dr[31:1]};
      st <= tap_next(st, tms[g]);
      if (rise_cnt < 4096) begin
        tms_hist[rise_cnt] <= tms[g];
        st_hist[rise_cnt]  <= tap_next(st, tms[g]);
      end
      rise_cnt <= rise_cnt + 1;
    end

    always @(negedge tck[g]) tdo_m <= (st == SH_DR) ? dr[0] : 1'b1;

    assign tdo[g] = stuck[g] ? 1'b1 : tdo_m;

    jtag_idcode_reader #(.TCK_DIV(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .idcode (idcode[g]),
      .id_err (id_err[g]),
      .tck    (tck[g]),
      .tms    (tms[g]),
      .tdi    (tdi[g]),
      .tdo    (tdo[g])
    );
  end

  // One read on instance g; optional extra start mid-sequence and in DONE.
  task automatic do_read(input int g, input logic [31:0] val, input bit stk,
                         input int restart_at, input bit pulse_in_done);
    int d, blen, first_hi, dones;
    logic [31:0] exp_id;
    d      = div_of(g);
    exp_id = stk ? 32'hFFFF_FFFF : val;
    idval[g] = val;
    stuck[g] = stk;
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    n_chk++;
    if (busy[g] !== 1'b1 || tms[g] !== 1'b1 || tck[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_resp[%0d]: busy=%b tms=%b tck=%b, required 1 1 0", g, busy[g], tms[g], tck[g]);
    end
    blen = 0; first_hi = -1; dones = 0;
    while (busy[g] === 1'b1 && blen < 4000) begin
      if (tck[g] === 1'b1 && first_hi < 0) first_hi = blen;
      if (done[g] === 1'b1) dones++;
      start[g] = (blen == restart_at);
      blen++;
      @(negedge clk);
    end
    start[g] = 1'b0;
    n_chk++;
    if (first_hi != d) begin
      n_fail++;
      $display("FAIL first_tck_rise[%0d]: %0d clks after busy, required %0d", g, first_hi, d);
    end
    n_chk++;
    if (blen != 86 * d) begin
      n_fail++;
      $display("FAIL busy_len[%0d]: %0d, required %0d", g, blen, 86 * d);
    end
    n_chk++;
    if (done[g] !== 1'b1 || dones != 0 || tck[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse[%0d]: done=%b early=%0d tck=%b, required 1 0 0", g, done[g], dones, tck[g]);
    end
    n_chk++;
    if (idcode[g] !== exp_id) begin
      n_fail++;
      $display("FAIL idcode[%0d]: %h, required %h", g, idcode[g], exp_id);
    end
    n_chk++;
    if (id_err[g] !== exp_err(exp_id)) begin
      n_fail++;
      $display("FAIL id_err[%0d]: %b, required %b", g, id_err[g], exp_err(exp_id));
    end
    if (pulse_in_done) start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    n_chk++;
    if (done[g] !== 1'b0 || busy[g] !== 1'b0 || idcode[g] !== exp_id) begin
      n_fail++;
      $display("FAIL after_done[%0d]: done=%b busy=%b idcode=%h, required 0 0 %h", g, done[g], busy[g], idcode[g], exp_id);
    end
  endtask

  task automatic check_reset_vals(input int g, input string tag);
    n_chk++;
    if ({busy[g], done[g], idcode[g], id_err[g], tck[g], tms[g], tdi[g]} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL %s[%0d]: busy=%b done=%b idcode=%h id_err=%b tck=%b tms=%b tdi=%b, required 0 0 0 0 0 1 1",
               tag, g, busy[g], done[g], idcode[g], id_err[g], tck[g], tms[g], tdi[g]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check_reset_vals(g, "reset_vals");
    // rst beats a coincident start
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    rst = 1'b0;
    check_reset_vals(0, "rst_over_start");
    @(negedge clk);
    check_reset_vals(0, "idle_after_rst");
  endtask

  task automatic test_basic_waveform();
    int base, rises;
    bit [42:0] obs_tms, exp_tms;
    base = tap[0].rise_cnt;
    do_read(0, 32'h1234_5679, 1'b0, -1, 1'b0);
    rises = tap[0].rise_cnt - base;
    n_chk++;
    if (rises != 43) begin
      n_fail++;
      $display("FAIL tck_rises: %0d, required 43", rises);
    end
    for (int i = 0; i < 43; i++) begin
      exp_tms[42 - i] = (i < 5) || (i == 6) || (i == 40) || (i == 41);
      obs_tms[42 - i] = tap[0].tms_hist[base + i];
    end
    n_chk++;
    if (obs_tms !== exp_tms) begin
      n_fail++;
      $display("FAIL tms_seq: %b, required %b", obs_tms, exp_tms);
    end
    n_chk++;
    if (tap[0].st_hist[base + 4] != TLR || tap[0].st_hist[base + 8] != SH_DR ||
        tap[0].st_hist[base + 40] != EX1_DR || tap[0].st_hist[base + 41] != UPD_DR ||
        tap[0].st_hist[base + 42] != RTI) begin
      n_fail++;
      $display("FAIL tap_states: %0d %0d %0d %0d %0d, required %0d %0d %0d %0d %0d",
               tap[0].st_hist[base + 4], tap[0].st_hist[base + 8], tap[0].st_hist[base + 40],
               tap[0].st_hist[base + 41], tap[0].st_hist[base + 42], TLR, SH_DR, EX1_DR, UPD_DR, RTI);
    end
  endtask

  task automatic test_integrity();
    do_read(0, 32'hA5A5_0F0F, 1'b1, -1, 1'b0);   // tdo stuck high
    do_read(0, 32'h1234_5678, 1'b0, -1, 1'b0);   // LSB clear
    do_read(0, 32'h1234_5679, 1'b0, -1, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_read(0, 32'h0BAD_CAFF, 1'b0, 50, 1'b1);
    repeat (10) @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_start: busy=%b done=%b, required 0 0", busy[0], done[0]);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    idval[0] = 32'h7654_3211;
    stuck[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (98) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals(0, "mid_rst");
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1 || busy[0] === 1'b1) dones++;
    end
    n_chk++;
    if (dones != 0 || idcode[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst_quiet: activity=%0d idcode=%h, required 0 00000000", dones, idcode[0]);
    end
    do_read(0, 32'h7654_3211, 1'b0, -1, 1'b0);
  endtask

  task automatic test_divisors_random();
    logic [31:0] v;
    do_read(1, 32'h1234_5679, 1'b0, -1, 1'b0);
    do_read(2, 32'h1234_5679, 1'b0, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[0] = 1'b1;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_read(k % 3, v, 1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_read(1, 32'hCAFE_0001, 1'b0, -1, 1'b0);
    do_read(1, 32'h0000_0003, 1'b0, -1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      stuck[g] = 1'b0;
      idval[g] = 32'h0;
    end
    test_reset();
    test_basic_waveform();
    test_integrity();
    test_ignore_start();
    test_reset_mid();
    test_divisors_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
